adc_sample_sequencer: RTL and testbench

Control stage directly upstream and downstream of the ADC model. It issues periodic single-cycle conversion triggers and collects the returned measurements, averaging 2^avg_shift samples with a per-conversion timeout. Averaged results are buffered in a small FIFO with a valid/ready output toward the bus-side register block, and sticky status flags are exposed.

---
 rtl/adc_sample_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
//   Issues periodic single-cycle conversion triggers to the ADC, collects the
//   returned measurements and averages 2^avg_shift of them. A conversion that
//   gets no answer within TIMEOUT cycles is abandoned and the partial average
//   is thrown away. Averaged results go into a small FIFO with a valid/ready
//   handshake toward the bus-side register block.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   enable       run the sequencer (looked at only while idle or waiting)
//   period       cycles between triggers, 0 behaves as 1
//   avg_shift    log2 of the number of samples per average, latched at trigger
//   adc_trigger  one-cycle conversion request
//   adc_valid    measurement strobe, only honoured while converting
//   adc_data     measurement value
//   out_valid    FIFO not empty
//   out_ready    consumer takes out_data this cycle
//   out_data     FIFO head
//   clear_flags  clears the sticky status bits
//   status       [0] busy, [1] timeout sticky, [2] overflow sticky,
//                [7:3] FIFO level
module adc_sample_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           period,
  input  logic [1:0]            avg_shift,
  output logic                  adc_trigger,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  clear_flags,
  output logic [7:0]            status
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int ACC_W = DATA_WIDTH + 3;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRIGGER = 2'd1,
    S_CONVERT = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_trig;
  logic [15:0]           r_period_cnt;
  logic [TW-1:0]         r_tmo_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [3:0]            r_cnt;
  logic [1:0]            r_shift;
  logic                  r_tmo_flag;
  logic                  r_ovf_flag;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [ACC_W-1:0]      w_acc_sum;
  logic [3:0]            w_cnt_inc;
  logic                  w_avg_done;
  logic                  w_sample;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_timeout;
  logic [15:0]           w_period_dec;
  logic [15:0]           w_period_load;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr_en;
  logic                  w_ovf_set;
  logic [4:0]            w_level;

  // Datapath decode: sample accumulation, average completion, timeout, FIFO handshake
  always_comb begin
    w_acc_sum     = r_acc + ACC_W'(adc_data);
    w_cnt_inc     = r_cnt + 4'd1;
    // ">=" so a shift lowered mid-average completes on the very next sample
    w_avg_done    = (w_cnt_inc >= (4'd1 << r_shift));
    w_sample      = (r_state == S_CONVERT) && adc_valid;
    w_push        = w_sample && w_avg_done;
    w_push_data   = DATA_WIDTH'(w_acc_sum >> r_shift);
    // A strobe on the expiry cycle wins, hence the !adc_valid term
    w_timeout     = (r_state == S_CONVERT) && !adc_valid &&
                    (r_tmo_cnt == TW'(TIMEOUT - 1));
    w_period_dec  = (r_period_cnt == 16'd0) ? 16'd0 : (r_period_cnt - 16'd1);
    w_period_load = (period == 16'd0) ? 16'd0 : (period - 16'd1);
    w_full        = (r_count == CW'(FIFO_DEPTH));
    w_pop         = (r_count != {CW{1'b0}}) && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    w_wr_en       = w_push && (!w_full || w_pop);
    w_ovf_set     = w_push && w_full && !w_pop;
    w_level       = 5'(r_count);
  end

  // Sequencer FSM with accumulator, counters and the registered trigger pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_trig       <= 1'b0;
      r_period_cnt <= 16'd0;
      r_tmo_cnt    <= {TW{1'b0}};
      r_acc        <= {ACC_W{1'b0}};
      r_cnt        <= 4'd0;
      r_shift      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc <= {ACC_W{1'b0}};
          r_cnt <= 4'd0;
          if (enable) begin
            r_state <= S_TRIGGER;
            r_trig  <= 1'b1;
          end else begin
            r_trig  <= 1'b0;
          end
        end
        S_TRIGGER: begin
          r_trig       <= 1'b0;
          r_period_cnt <= w_period_load;
          r_tmo_cnt    <= {TW{1'b0}};
          r_shift      <= avg_shift;
          r_state      <= S_CONVERT;
        end
        S_CONVERT: begin
          r_trig       <= 1'b0;
          r_period_cnt <= w_period_dec;
          r_tmo_cnt    <= r_tmo_cnt + TW'(1);
          if (adc_valid) begin
            if (w_avg_done) begin
              r_acc <= {ACC_W{1'b0}};
              r_cnt <= 4'd0;
            end else begin
              r_acc <= w_acc_sum;
              r_cnt <= w_cnt_inc;
            end
            r_state <= S_WAIT;
          end else if (w_timeout) begin
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= 4'd0;
            r_state <= S_WAIT;
          end else begin
            r_state <= S_CONVERT;
          end
        end
        S_WAIT: begin
          r_period_cnt <= w_period_dec;
          if (!enable) begin
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= 4'd0;
            r_trig  <= 1'b0;
            r_state <= S_IDLE;
          // Counter reaching 0 on this edge: trigger lands exactly one period
          // after the previous one (or right away if the conversion ran long)
          end else if (r_period_cnt <= 16'd1) begin
            r_trig  <= 1'b1;
            r_state <= S_TRIGGER;
          end else begin
            r_trig  <= 1'b0;
          end
        end
        default: begin
          r_trig  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result FIFO storage, pointers and fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_tmo_flag <= w_timeout ? 1'b1 : (clear_flags ? 1'b0 : r_tmo_flag);
      r_ovf_flag <= w_ovf_set ? 1'b1 : (clear_flags ? 1'b0 : r_ovf_flag);
    end
  end

  assign adc_trigger = r_trig;
  assign out_valid   = (r_count != {CW{1'b0}});
  assign out_data    = r_mem[r_rd_ptr];
  assign status      = {w_level, r_ovf_flag, r_tmo_flag, (r_state != S_IDLE)};

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer. The bench plays the ADC and
// the consumer, and predicts triggers, results, FIFO contents and flags from
// trigger timestamps, a list of pending samples and a queue of results.
module tb_adc_sample_sequencer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          reset, enable, adc_valid, out_ready, clear_flags;
  logic [15:0]   period;
  logic [1:0]    avg_shift;
  logic [DW-1:0] adc_data;
  logic          adc_trigger, out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    status;

  adc_sample_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .avg_shift(avg_shift), .adc_trigger(adc_trigger), .adc_valid(adc_valid),
    .adc_data(adc_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .clear_flags(clear_flags), .status(status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  bit            m_active;
  int            exp_trig, cur_trig, cur_end, cur_L, cur_shift;
  longint        acc_q[$];
  logic [DW-1:0] fifo_q[$];
  logic          m_tmo, m_ovf;
  int            lat_fixed = -1;   // -1 random latency, 0 never answer, N answer N cycles after trigger
  logic [DW-1:0] data_q[$];
  int            ready_mode = 1;   // 0 never, 1 always, 2 random

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; exp_trig = -1; cur_trig = -1000; cur_end = -1000;
    cur_L = -1; cur_shift = 0; acc_q.delete(); fifo_q.delete();
    m_tmo = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_trigger"}, adc_trigger, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_status"}, status, 8'h00);
  endtask

  // One clock cycle: check outputs, drive ADC/consumer, advance the model, clock.
  task automatic cycle_once();
    bit            exp_t, sample, pop, push, tmo_ev, dropped;
    logic [7:0]    exp_status;
    logic [DW-1:0] res;
    longint        sum;
    int            p;
    exp_t = m_active && (cyc == exp_trig);
    chk("trigger", adc_trigger, exp_t);
    chk("out_valid", out_valid, fifo_q.size() > 0);
    if (fifo_q.size() > 0) chk("out_data", out_data, fifo_q[0]);
    exp_status = {5'(fifo_q.size()), m_ovf, m_tmo, m_active};
    chk("status", status, exp_status);

    if (exp_t) begin
      cur_trig  = cyc;
      cur_shift = avg_shift;
      p = (period == 16'd0) ? 1 : int'(period);
      if (lat_fixed >= 0) cur_L = lat_fixed;
      else cur_L = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
      cur_end  = cyc + ((cur_L != 0) ? cur_L : TMO);
      exp_trig = cyc + (((cur_end - cyc + 2) > p) ? (cur_end - cyc + 2) : p);
    end

    sample = m_active && (cur_L > 0) && (cyc == cur_trig + cur_L);
    adc_valid = sample;
    // stray strobes while not converting must be ignored
    if (!sample && (cyc > cur_end || !m_active) && $urandom_range(0, 7) == 0) adc_valid = 1'b1;
    if (sample && data_q.size() > 0) adc_data = data_q.pop_front();
    else adc_data = $urandom;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);

    pop = out_ready && (fifo_q.size() > 0);
    push = 1'b0; tmo_ev = 1'b0; dropped = 1'b0; res = '0;
    if (sample) begin
      acc_q.push_back(longint'(adc_data));
      if (acc_q.size() >= (1 << cur_shift)) begin
        sum = 0;
        foreach (acc_q[i]) sum += acc_q[i];
        res = DW'(sum >>> cur_shift);
        acc_q.delete();
        push = 1'b1;
      end
    end
    if (m_active && cur_L == 0 && cyc == cur_end) begin
      tmo_ev = 1'b1;
      acc_q.delete();
    end
    if (pop) void'(fifo_q.pop_front());
    if (push) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(res);
      else dropped = 1'b1;
    end
    m_tmo = tmo_ev  ? 1'b1 : (clear_flags ? 1'b0 : m_tmo);
    m_ovf = dropped ? 1'b1 : (clear_flags ? 1'b0 : m_ovf);
    if (m_active && !enable && cyc > cur_end && cyc < exp_trig) begin
      m_active = 1'b0;
      acc_q.delete();
    end else if (!m_active && enable) begin
      m_active = 1'b1;
      exp_trig = cyc + 1;
      cur_end  = cyc;
      cur_L    = -1;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_once();
  endtask

  initial begin
    bit hit;
    reset = 1'b1; enable = 1'b0; adc_valid = 1'b0; out_ready = 1'b0;
    clear_flags = 1'b0; period = 16'd0; avg_shift = 2'd0; adc_data = '0;
    model_reset();
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    check_reset_outputs("por");
    reset = 1'b0;

    // idle with enable low
    run(5);

    // periodic triggers, single-sample averages of 0x10 answered 2 cycles late
    period = 16'd10; avg_shift = 2'd0; lat_fixed = 2; ready_mode = 1;
    for (int i = 0; i < 6; i++) data_q.push_back(32'h10);
    enable = 1'b1;
    run(45);

    // four-sample average of 1,2,3,6
    data_q.delete();
    data_q.push_back(32'd1); data_q.push_back(32'd2);
    data_q.push_back(32'd3); data_q.push_back(32'd6);
    avg_shift = 2'd2;
    run(48);
    avg_shift = 2'd0;
    run(40);

    // timeout, clear, coincident strobe, timeout under a held clear
    period = 16'd100; lat_fixed = 0;
    run(170);
    clear_flags = 1'b1; cycle_once(); clear_flags = 1'b0;
    lat_fixed = TMO;
    run(100);
    lat_fixed = 0; clear_flags = 1'b1;
    run(100);
    clear_flags = 1'b0;
    run(5);

    // overflow with a stalled consumer, then drain
    period = 16'd5; lat_fixed = 2; ready_mode = 0;
    run(110);
    chk("ovf_level", status[7:3], 5'd4);
    chk("ovf_flag", status[2], 1'b1);
    enable = 1'b0; ready_mode = 1;
    run(20);
    chk("drained", out_valid, 1'b0);
    clear_flags = 1'b1; cycle_once(); clear_flags = 1'b0;
    enable = 1'b1;

    // randomized operation
    lat_fixed = -1; ready_mode = 2;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 59) == 0) period = 16'($urandom_range(0, 8));
      if ($urandom_range(0, 39) == 0) avg_shift = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      clear_flags = ($urandom_range(0, 19) == 0);
      cycle_once();
    end
    clear_flags = 1'b0; enable = 1'b1;

    // reset in the middle of a conversion with two results queued
    ready_mode = 0; period = 16'd4; lat_fixed = 3; avg_shift = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (fifo_q.size() == 2 && m_active && cyc > cur_trig && cyc <= cur_end) hit = 1'b1;
      else cycle_once();
    end
    chk("reset_setup_reached", hit, 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1; cyc++;
    check_reset_outputs("held_reset");
    model_reset();
    reset = 1'b0; lat_fixed = -1; ready_mode = 1;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
